// File: rtl/fight_referee.sv
// fight_referee: combat controller above the two character animation FSMs.
// Detects hits on each frame tick, applies damage to hit points, drives the
// characters' hurt inputs and sequences the round (IDLE -> FIGHT -> OVER).
// Optional feature macro: ROUND_TIMER_EN enables the round timer and the
// timeout exit; without it time_left is a constant ROUND_SEC and only a KO
// ends the round.
module fight_referee #(
    parameter int MAX_HP        = 100,
    parameter int DAMAGE        = 10,
    parameter int CHIP_DAMAGE   = 2,
    parameter int HIT_FRAME     = 4,
    parameter int REACH         = 64,
    parameter int TICKS_PER_SEC = 60,
    parameter int ROUND_SEC     = 99
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic [7:0] p1_state,
    input  logic [7:0] p1_frame,
    input  logic [7:0] p2_state,
    input  logic [7:0] p2_frame,
    input  logic [9:0] p1_x,
    input  logic [9:0] p2_x,
    output logic       p1_hurt,
    output logic       p2_hurt,
    output logic [6:0] p1_hp,
    output logic [6:0] p2_hp,
    output logic [6:0] time_left,
    output logic       fight_en,
    output logic [1:0] game_state,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIGHT = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    localparam logic [6:0]  MAX_HP_C    = 7'(MAX_HP);
    localparam logic [6:0]  DAMAGE_C    = 7'(DAMAGE);
    localparam logic [6:0]  CHIP_C      = 7'(CHIP_DAMAGE);
    localparam logic [7:0]  HIT_FRAME_C = 8'(HIT_FRAME);
    localparam logic [10:0] REACH_C     = 11'(REACH);
    localparam logic [6:0]  ROUND_SEC_C = 7'(ROUND_SEC);
    localparam logic [7:0]  ST_ATTACK_C = 8'd1;
    localparam logic [7:0]  ST_DEFEND_C = 8'd5;

    // HP never wraps: a hit bigger than the remaining HP leaves zero.
    function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? (a - b) : 7'd0;
    endfunction

    state_e      state_q, state_d;
    logic        fc_sync_q, fc_prev_q, tick_q;
    logic [6:0]  p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic        p1_hurt_q, p1_hurt_d, p2_hurt_q, p2_hurt_d;
    logic        p1_hold_q, p1_hold_d, p2_hold_q, p2_hold_d;
    logic        p1_done_q, p1_done_d, p2_done_q, p2_done_d;
    logic [1:0]  winner_q, winner_d;
    logic        fight_en_q, fight_en_d;
    logic [10:0] dx_s;
    logic        p1_hit_s, p2_hit_s, start_s, timeout_s;
`ifdef ROUND_TIMER_EN
    logic [6:0]  time_left_q, time_left_d;
    logic [6:0]  sub_q, sub_d;
`endif

    // Hit detection: 11-bit absolute distance and per-player hit qualifiers.
    always_comb begin
        if (p1_x >= p2_x) begin
            dx_s = {1'b0, p1_x} - {1'b0, p2_x};
        end else begin
            dx_s = {1'b0, p2_x} - {1'b0, p1_x};
        end
        p1_hit_s = (p1_state == ST_ATTACK_C) && (p1_frame == HIT_FRAME_C) &&
                   !p1_done_q && (dx_s <= REACH_C);
        p2_hit_s = (p2_state == ST_ATTACK_C) && (p2_frame == HIT_FRAME_C) &&
                   !p2_done_q && (dx_s <= REACH_C);
        start_s  = start && (state_q != ST_FIGHT);
    end

    // Next-state logic for the round sequencer and all game registers.
    always_comb begin
        state_d   = state_q;
        p1_hp_d   = p1_hp_q;
        p2_hp_d   = p2_hp_q;
        p1_hurt_d = p1_hurt_q;
        p2_hurt_d = p2_hurt_q;
        p1_hold_d = p1_hold_q;
        p2_hold_d = p2_hold_q;
        p1_done_d = p1_done_q;
        p2_done_d = p2_done_q;
        winner_d  = winner_q;
        timeout_s = 1'b0;
`ifdef ROUND_TIMER_EN
        time_left_d = time_left_q;
        sub_d       = sub_q;
`endif
        if (start_s) begin
            // Start is sampled every clock, not only on ticks.
            state_d   = ST_FIGHT;
            p1_hp_d   = MAX_HP_C;
            p2_hp_d   = MAX_HP_C;
            p1_hurt_d = 1'b0;
            p2_hurt_d = 1'b0;
            p1_hold_d = 1'b0;
            p2_hold_d = 1'b0;
            p1_done_d = 1'b0;
            p2_done_d = 1'b0;
            winner_d  = 2'd0;
`ifdef ROUND_TIMER_EN
            time_left_d = ROUND_SEC_C;
            sub_d       = 7'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_OVER: begin
                    if (tick_q) begin
                        p1_hurt_d = 1'b0;
                        p2_hurt_d = 1'b0;
                        p1_hold_d = 1'b0;
                        p2_hold_d = 1'b0;
                    end else begin
                        state_d = ST_OVER;
                    end
                end
                ST_FIGHT: begin
                    if (tick_q) begin
                        // Done flag: set by a landed hit, cleared once the attack ends.
                        if (p1_hit_s) begin
                            p1_done_d = 1'b1;
                        end else if (p1_state != ST_ATTACK_C) begin
                            p1_done_d = 1'b0;
                        end else begin
                            p1_done_d = p1_done_q;
                        end
                        if (p2_hit_s) begin
                            p2_done_d = 1'b1;
                        end else if (p2_state != ST_ATTACK_C) begin
                            p2_done_d = 1'b0;
                        end else begin
                            p2_done_d = p2_done_q;
                        end

                        // Damage: a defending victim only takes chip damage.
                        if (p1_hit_s) begin
                            p2_hp_d = sat_sub(p2_hp_q, (p2_state == ST_DEFEND_C) ? CHIP_C : DAMAGE_C);
                        end else begin
                            p2_hp_d = p2_hp_q;
                        end
                        if (p2_hit_s) begin
                            p1_hp_d = sat_sub(p1_hp_q, (p1_state == ST_DEFEND_C) ? CHIP_C : DAMAGE_C);
                        end else begin
                            p1_hp_d = p1_hp_q;
                        end

                        // Hurt stays high for the hit tick and one further tick so the
                        // character FSM is sure to see it on its own frame edge.
                        if (p1_hit_s && (p2_state != ST_DEFEND_C)) begin
                            p2_hurt_d = 1'b1;
                            p2_hold_d = 1'b1;
                        end else if (p2_hold_q) begin
                            p2_hurt_d = 1'b1;
                            p2_hold_d = 1'b0;
                        end else begin
                            p2_hurt_d = 1'b0;
                            p2_hold_d = 1'b0;
                        end
                        if (p2_hit_s && (p1_state != ST_DEFEND_C)) begin
                            p1_hurt_d = 1'b1;
                            p1_hold_d = 1'b1;
                        end else if (p1_hold_q) begin
                            p1_hurt_d = 1'b1;
                            p1_hold_d = 1'b0;
                        end else begin
                            p1_hurt_d = 1'b0;
                            p1_hold_d = 1'b0;
                        end

`ifdef ROUND_TIMER_EN
                        if (sub_q == 7'(TICKS_PER_SEC - 1)) begin
                            sub_d = 7'd0;
                            if (time_left_q != 7'd0) begin
                                time_left_d = time_left_q - 7'd1;
                            end else begin
                                time_left_d = 7'd0;
                            end
                        end else begin
                            sub_d = sub_q + 7'd1;
                        end
                        timeout_s = (time_left_d == 7'd0);
`endif

                        // KO uses post-update HP and wins over a same-tick timeout.
                        if ((p1_hp_d == 7'd0) || (p2_hp_d == 7'd0)) begin
                            state_d = ST_OVER;
                            if ((p1_hp_d == 7'd0) && (p2_hp_d == 7'd0)) begin
                                winner_d = 2'd3;
                            end else if (p2_hp_d == 7'd0) begin
                                winner_d = 2'd1;
                            end else begin
                                winner_d = 2'd2;
                            end
                        end else if (timeout_s) begin
                            state_d = ST_OVER;
                            if (p1_hp_d > p2_hp_d) begin
                                winner_d = 2'd1;
                            end else if (p2_hp_d > p1_hp_d) begin
                                winner_d = 2'd2;
                            end else begin
                                winner_d = 2'd3;
                            end
                        end else begin
                            state_d = ST_FIGHT;
                        end
                    end else begin
                        state_d = ST_FIGHT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        fight_en_d = (state_d == ST_FIGHT);
    end

    // Register file: frame tick edge detector plus every game register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_sync_q  <= 1'b0;
            fc_prev_q  <= 1'b0;
            tick_q     <= 1'b0;
            state_q    <= ST_IDLE;
            p1_hp_q    <= MAX_HP_C;
            p2_hp_q    <= MAX_HP_C;
            p1_hurt_q  <= 1'b0;
            p2_hurt_q  <= 1'b0;
            p1_hold_q  <= 1'b0;
            p2_hold_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p2_done_q  <= 1'b0;
            winner_q   <= 2'd0;
            fight_en_q <= 1'b0;
`ifdef ROUND_TIMER_EN
            time_left_q <= ROUND_SEC_C;
            sub_q       <= 7'd0;
`endif
        end else begin
            fc_sync_q  <= frame_clk;
            fc_prev_q  <= fc_sync_q;
            tick_q     <= fc_sync_q & ~fc_prev_q;
            state_q    <= state_d;
            p1_hp_q    <= p1_hp_d;
            p2_hp_q    <= p2_hp_d;
            p1_hurt_q  <= p1_hurt_d;
            p2_hurt_q  <= p2_hurt_d;
            p1_hold_q  <= p1_hold_d;
            p2_hold_q  <= p2_hold_d;
            p1_done_q  <= p1_done_d;
            p2_done_q  <= p2_done_d;
            winner_q   <= winner_d;
            fight_en_q <= fight_en_d;
`ifdef ROUND_TIMER_EN
            time_left_q <= time_left_d;
            sub_q       <= sub_d;
`endif
        end
    end

    assign p1_hurt    = p1_hurt_q;
    assign p2_hurt    = p2_hurt_q;
    assign p1_hp      = p1_hp_q;
    assign p2_hp      = p2_hp_q;
    assign fight_en   = fight_en_q;
    assign game_state = state_q;
    assign winner     = winner_q;
`ifdef ROUND_TIMER_EN
    assign time_left  = time_left_q;
`else
    assign time_left  = ROUND_SEC_C;
`endif

endmodule

// File: tb/tb_fight_referee.sv
// Directed bench for fight_referee: a vector table for single-tick hit
// behaviour plus hand sequences for trades/KO, saturation, timer and reset.
module tb_fight_referee;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, start;
    logic [7:0] p1_state, p1_frame, p2_state, p2_frame;
    logic [9:0] p1_x, p2_x;
    logic       p1_hurt, p2_hurt, fight_en;
    logic [6:0] p1_hp, p2_hp, time_left;
    logic [1:0] game_state, winner;

    int n_vec  = 0;
    int n_fail = 0;

    fight_referee dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .p1_state(p1_state), .p1_frame(p1_frame),
        .p2_state(p2_state), .p2_frame(p2_frame),
        .p1_x(p1_x), .p2_x(p2_x),
        .p1_hurt(p1_hurt), .p2_hurt(p2_hurt),
        .p1_hp(p1_hp), .p2_hp(p2_hp), .time_left(time_left),
        .fight_en(fight_en), .game_state(game_state), .winner(winner)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] s1, f1, s2, f2;
        logic [9:0] x1, x2;
        int         hp1, hp2, h1, h2;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame tick: rising edge on frame_clk, then enough clocks for the
    // synchroniser, tick pulse and register update to complete.
    task automatic do_tick();
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] s1, f1, s2, f2, input logic [9:0] x1, x2);
        p1_state = s1; p1_frame = f1; p2_state = s2; p2_frame = f2;
        p1_x = x1; p2_x = x2;
    endtask

    task automatic start_round();
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    // One complete attack by P1 (who=0) or P2 (who=1); def puts victim in defend.
    task automatic hit(input bit who, input bit def);
        if (who == 1'b0) set_in(8'd1, 8'd4, def ? 8'd5 : 8'd0, 8'd0, 10'd100, 10'd140);
        else             set_in(def ? 8'd5 : 8'd0, 8'd0, 8'd1, 8'd4, 10'd100, 10'd140);
        do_tick();
        set_in(8'd0, 8'd0, 8'd0, 8'd0, 10'd100, 10'd140);
        do_tick();
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; start = 1'b0;
        set_in(8'd0, 8'd0, 8'd0, 8'd0, 10'd100, 10'd140);

        //            s1 f1 s2 f2 x1   x2  | hp1 hp2 h1 h2
        vecs[0]  = '{8'd1, 8'd0, 8'd0, 8'd0, 10'd100, 10'd140, 100, 100, 0, 0};
        vecs[1]  = '{8'd1, 8'd1, 8'd0, 8'd0, 10'd100, 10'd140, 100, 100, 0, 0};
        vecs[2]  = '{8'd1, 8'd2, 8'd0, 8'd0, 10'd100, 10'd140, 100, 100, 0, 0};
        vecs[3]  = '{8'd1, 8'd3, 8'd0, 8'd0, 10'd100, 10'd140, 100, 100, 0, 0};
        vecs[4]  = '{8'd1, 8'd4, 8'd0, 8'd0, 10'd100, 10'd140, 100,  90, 0, 1};
        vecs[5]  = '{8'd1, 8'd5, 8'd0, 8'd0, 10'd100, 10'd140, 100,  90, 0, 1};
        vecs[6]  = '{8'd1, 8'd6, 8'd0, 8'd0, 10'd100, 10'd140, 100,  90, 0, 0};
        vecs[7]  = '{8'd1, 8'd4, 8'd0, 8'd0, 10'd100, 10'd140, 100,  90, 0, 0};
        vecs[8]  = '{8'd1, 8'd8, 8'd0, 8'd0, 10'd100, 10'd140, 100,  90, 0, 0};
        vecs[9]  = '{8'd0, 8'd0, 8'd0, 8'd0, 10'd100, 10'd140, 100,  90, 0, 0};
        vecs[10] = '{8'd1, 8'd3, 8'd5, 8'd0, 10'd100, 10'd140, 100,  90, 0, 0};
        vecs[11] = '{8'd1, 8'd4, 8'd5, 8'd0, 10'd100, 10'd140, 100,  88, 0, 0};
        vecs[12] = '{8'd1, 8'd5, 8'd5, 8'd0, 10'd100, 10'd140, 100,  88, 0, 0};
        vecs[13] = '{8'd0, 8'd0, 8'd0, 8'd0, 10'd100, 10'd140, 100,  88, 0, 0};
        vecs[14] = '{8'd1, 8'd4, 8'd0, 8'd0, 10'd100, 10'd165, 100,  88, 0, 0};
        vecs[15] = '{8'd0, 8'd0, 8'd0, 8'd0, 10'd100, 10'd165, 100,  88, 0, 0};
        vecs[16] = '{8'd1, 8'd4, 8'd0, 8'd0, 10'd100, 10'd164, 100,  78, 0, 1};
        vecs[17] = '{8'd0, 8'd0, 8'd0, 8'd0, 10'd300, 10'd250, 100,  78, 0, 1};
        vecs[18] = '{8'd0, 8'd0, 8'd1, 8'd4, 10'd300, 10'd250,  90,  78, 1, 0};
        vecs[19] = '{8'd4, 8'd0, 8'd1, 8'd5, 10'd300, 10'd250,  90,  78, 1, 0};
        vecs[20] = '{8'd0, 8'd0, 8'd0, 8'd0, 10'd300, 10'd250,  90,  78, 0, 0};
        vecs[21] = '{8'd5, 8'd0, 8'd1, 8'd4, 10'd300, 10'd250,  88,  78, 0, 0};
        vecs[22] = '{8'd2, 8'd4, 8'd0, 8'd0, 10'd300, 10'd235,  88,  78, 0, 0};
        vecs[23] = '{8'd0, 8'd0, 8'd1, 8'd4, 10'd300, 10'd235,  88,  78, 0, 0};

        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state
        chk("rst.game_state", int'(game_state), 0);
        chk("rst.p1_hp", int'(p1_hp), 100);
        chk("rst.p2_hp", int'(p2_hp), 100);
        chk("rst.time_left", int'(time_left), 99);
        chk("rst.winner", int'(winner), 0);
        chk("rst.fight_en", int'(fight_en), 0);
        chk("rst.hurt", int'({p1_hurt, p2_hurt}), 0);

        // IDLE holds without start, even across ticks
        do_tick();
        chk("idle.game_state", int'(game_state), 0);

        start_round();
        chk("start.game_state", int'(game_state), 1);
        chk("start.fight_en", int'(fight_en), 1);
        chk("start.winner", int'(winner), 0);

        for (int i = 0; i < 24; i++) begin
            set_in(vecs[i].s1, vecs[i].f1, vecs[i].s2, vecs[i].f2, vecs[i].x1, vecs[i].x2);
            do_tick();
            chk($sformatf("vec%0d.p1_hp", i), int'(p1_hp), vecs[i].hp1);
            chk($sformatf("vec%0d.p2_hp", i), int'(p2_hp), vecs[i].hp2);
            chk($sformatf("vec%0d.p1_hurt", i), int'(p1_hurt), vecs[i].h1);
            chk($sformatf("vec%0d.p2_hurt", i), int'(p2_hurt), vecs[i].h2);
            chk($sformatf("vec%0d.game_state", i), int'(game_state), 1);
        end

        // Trades: ten simultaneous hits take both players from 100 to 0 -> draw
        Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
        start_round();
        for (int t = 0; t < 10; t++) begin
            set_in(8'd1, 8'd4, 8'd1, 8'd4, 10'd200, 10'd210);
            do_tick();
            if (t == 8) begin
                chk("trade9.p1_hp", int'(p1_hp), 10);
                chk("trade9.p2_hp", int'(p2_hp), 10);
                chk("trade9.game_state", int'(game_state), 1);
            end else if (t == 9) begin
                chk("ko.p1_hp", int'(p1_hp), 0);
                chk("ko.p2_hp", int'(p2_hp), 0);
                chk("ko.game_state", int'(game_state), 2);
                chk("ko.winner", int'(winner), 3);
                chk("ko.fight_en", int'(fight_en), 0);
                chk("ko.hurt", int'({p1_hurt, p2_hurt}), 3);
            end else begin
                chk("trade.game_state", int'(game_state), 1);
            end
            set_in(8'd0, 8'd0, 8'd0, 8'd0, 10'd200, 10'd210);
            do_tick();
        end
        chk("over.hurt_cleared", int'({p1_hurt, p2_hurt}), 0);
        chk("over.hold_hp", int'(p1_hp), 0);
        chk("over.hold_state", int'(game_state), 2);

        // Restart from OVER, then drive P2 through chip damage into saturation
        start_round();
        chk("restart.game_state", int'(game_state), 1);
        chk("restart.p1_hp", int'(p1_hp), 100);
        chk("restart.p2_hp", int'(p2_hp), 100);
        chk("restart.winner", int'(winner), 0);
        hit(1'b0, 1'b1);
        chk("chip.p2_hp", int'(p2_hp), 98);
        for (int k = 0; k < 9; k++) hit(1'b0, 1'b0);
        chk("sat.pre_p2_hp", int'(p2_hp), 8);
        hit(1'b0, 1'b0);
        chk("sat.p2_hp", int'(p2_hp), 0);
        chk("sat.p1_hp", int'(p1_hp), 100);
        chk("sat.game_state", int'(game_state), 2);
        chk("sat.winner", int'(winner), 1);

        // Round timer
        start_round();
        begin
            int n;
            hit(1'b1, 1'b0); hit(1'b1, 1'b0);
            hit(1'b0, 1'b0); hit(1'b0, 1'b0); hit(1'b0, 1'b0);
            n = 10;
            chk("timer.p1_hp", int'(p1_hp), 80);
            chk("timer.p2_hp", int'(p2_hp), 70);
`ifdef ROUND_TIMER_EN
            while (game_state == 2'd1 && n < 6000) begin
                do_tick();
                n++;
                if (n == 60) chk("timer.sec1", int'(time_left), 98);
            end
            chk("timeout.ticks", n, 5940);
            chk("timeout.time_left", int'(time_left), 0);
            chk("timeout.game_state", int'(game_state), 2);
            chk("timeout.winner", int'(winner), 1);
`else
            while (n < 200) begin
                do_tick();
                n++;
            end
            chk("notimer.game_state", int'(game_state), 1);
            chk("notimer.time_left", int'(time_left), 99);
            chk("notimer.winner", int'(winner), 0);
`endif
        end

        // Reset mid-round
        Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
        start_round();
        for (int k = 0; k < 5; k++) hit(1'b0, 1'b0);
        chk("mid.p2_hp", int'(p2_hp), 50);
        chk("mid.p2_hurt", int'(p2_hurt), 1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("midrst.game_state", int'(game_state), 0);
        chk("midrst.p2_hp", int'(p2_hp), 100);
        chk("midrst.hurt", int'({p1_hurt, p2_hurt}), 0);
        chk("midrst.fight_en", int'(fight_en), 0);
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
